// File: rtl/dca_matrix_lsu_read_sequencer.sv
// Matrix LSU read sequencer: walks a matrix-load instruction row by row, issuing one AR burst
// and one aligner txn-info word per row, and signals completion once every burst has returned.
module dca_matrix_lsu_read_sequencer #(
  parameter int unsigned BW_ADDR         = 32,
  parameter int unsigned BW_AXI_DATA     = 128,
  parameter int unsigned BW_ELEMENT      = 32,
  parameter int unsigned BW_NUM          = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inst_valid,
  output logic                                 inst_ready,
  input  logic [BW_ADDR-1:0]                   inst_addr,
  input  logic [BW_ADDR-4:0]                   inst_stride_ls3,
  input  logic [BW_NUM-1:0]                    inst_num_row_m1,
  input  logic [BW_NUM-1:0]                    inst_num_col_m1,
  output logic [BW_ADDR-1:0]                   araddr,
  output logic [7:0]                           arlen,
  output logic                                 arvalid,
  input  logic                                 arready,
  output logic                                 txn_valid,
  input  logic                                 txn_ready,
  output logic [10+$clog2(BW_AXI_DATA)-1:0]    txn_info,
  input  logic                                 rvalid,
  input  logic                                 rready,
  input  logic                                 rlast,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned BPB    = BW_AXI_DATA / 8;
  localparam int unsigned OFF_W  = $clog2(BPB);
  localparam int unsigned EB     = BW_ELEMENT / 8;
  localparam int unsigned SPAN_W = BW_NUM + $clog2(EB + 1) + 2;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [BW_ADDR-1:0]   cur_addr;
  logic [BW_ADDR-4:0]   stride_ls3;
  logic [BW_NUM-1:0]    num_row_m1;
  logic [BW_NUM-1:0]    num_col_m1;
  logic [BW_NUM-1:0]    row;
  logic                 calc;
  logic                 ar_done;
  logic                 txn_done;
  logic [CNT_W-1:0]     out_cnt;

  logic                 ar_hs;
  logic                 txn_hs;
  logic                 r_hs;
  logic                 ar_done_n;
  logic                 txn_done_n;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 cnt_room;
  logic [OFF_W-1:0]     off;
  logic [SPAN_W-1:0]    row_bytes;
  logic [SPAN_W-1:0]    span_m1;
  logic [7:0]           arlen_c;

  // Handshakes, outstanding-count update and row geometry for the current row address.
  always_comb begin
    ar_hs      = arvalid & arready;
    txn_hs     = txn_valid & txn_ready;
    r_hs       = rvalid & rready & rlast;
    ar_done_n  = ar_done | ar_hs;
    txn_done_n = txn_done | txn_hs;
    cnt_nxt    = out_cnt;
    if (ar_hs && !r_hs) begin
      cnt_nxt = out_cnt + CNT_W'(1);
    end else if (!ar_hs && r_hs && (out_cnt != '0)) begin
      cnt_nxt = out_cnt - CNT_W'(1);
    end
    cnt_room  = (cnt_nxt < CNT_W'(MAX_OUTSTANDING));
    off       = cur_addr[OFF_W-1:0];
    row_bytes = (SPAN_W'(num_col_m1) + SPAN_W'(1)) * SPAN_W'(EB);
    span_m1   = row_bytes + SPAN_W'(off) - SPAN_W'(1);
    arlen_c   = 8'(span_m1 >> OFF_W);
  end

  // Sequencer FSM with registered AR / txn / status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      stride_ls3 <= '0;
      num_row_m1 <= '0;
      num_col_m1 <= '0;
      row        <= '0;
      calc       <= 1'b0;
      ar_done    <= 1'b0;
      txn_done   <= 1'b0;
      out_cnt    <= '0;
      araddr     <= '0;
      arlen      <= '0;
      arvalid    <= 1'b0;
      txn_valid  <= 1'b0;
      txn_info   <= '0;
      inst_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      out_cnt <= cnt_nxt;
      case (state)
        IDLE: begin
          if (inst_valid && inst_ready) begin
            cur_addr   <= inst_addr;
            stride_ls3 <= inst_stride_ls3;
            num_row_m1 <= inst_num_row_m1;
            num_col_m1 <= inst_num_col_m1;
            row        <= '0;
            calc       <= 1'b1;
            ar_done    <= 1'b0;
            txn_done   <= 1'b0;
            inst_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (calc) begin
            araddr    <= {cur_addr[BW_ADDR-1:OFF_W], OFF_W'(0)};
            arlen     <= arlen_c;
            txn_info  <= {(row == num_row_m1), (row == '0), arlen_c, off, 3'b000};
            calc      <= 1'b0;
            arvalid   <= cnt_room;
            txn_valid <= 1'b1;
          end else if (ar_done_n && txn_done_n) begin
            arvalid   <= 1'b0;
            txn_valid <= 1'b0;
            ar_done   <= 1'b0;
            txn_done  <= 1'b0;
            if (row == num_row_m1) begin
              state <= DRAIN;
            end else begin
              row      <= row + BW_NUM'(1);
              cur_addr <= cur_addr + {stride_ls3, 3'b000};
              calc     <= 1'b1;
            end
          end else begin
            // AR may be held off by the outstanding limit while txn proceeds on its own.
            ar_done   <= ar_done_n;
            txn_done  <= txn_done_n;
            arvalid   <= !ar_done_n && cnt_room;
            txn_valid <= !txn_done_n;
          end
        end
        DRAIN: begin
          if (out_cnt == '0) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            inst_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_matrix_lsu_read_sequencer.sv
// Randomized bench for the matrix LSU read sequencer with a per-instruction row model and
// directed scenarios for alignment, outstanding limit, backpressure, wrap and reset.
module tb_dca_matrix_lsu_read_sequencer;

  localparam int MAXO = 4;

  logic        clk, rst, inst_valid, inst_ready;
  logic [31:0] inst_addr;
  logic [28:0] inst_stride_ls3;
  logic [7:0]  inst_num_row_m1, inst_num_col_m1;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready, txn_valid, txn_ready;
  logic [16:0] txn_info;
  logic        rvalid, rready, rlast, busy, done;

  dca_matrix_lsu_read_sequencer dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_addr(inst_addr), .inst_stride_ls3(inst_stride_ls3),
    .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_info(txn_info),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0, n_err = 0;
  int m_out = 0, n_ar = 0, n_tx = 0, n_done = 0;
  int ar_pct = 100, tx_pct = 100, r_pct = 100;
  bit inst_active = 0, want_inst = 0, do_rst = 0, force_r = 0, r_en = 0;
  logic [39:0] exp_ar[$];
  logic [16:0] exp_txn[$];
  logic [39:0] ar_log[$];
  logic [16:0] tx_log[$];
  bit          p_arv = 0, p_arr = 0, p_txv = 0, p_txr = 0;
  logic [31:0] p_araddr;
  logic [7:0]  p_arlen;
  logic [16:0] p_info;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Expected AR beats and txn words for every row of the instruction now on the inst_* bus.
  task automatic push_model();
    logic [31:0] a;
    int off, len, rows, cols;
    a = inst_addr;
    rows = int'(inst_num_row_m1);
    cols = int'(inst_num_col_m1);
    for (int r = 0; r <= rows; r++) begin
      off = int'(a[3:0]);
      len = (off + (cols + 1) * 4 + 15) / 16 - 1;
      exp_ar.push_back({8'(len), a - 32'(off)});
      exp_txn.push_back({(r == rows), (r == 0), 8'(len), 7'(off * 8)});
      a = a + {inst_stride_ls3, 3'b000};
    end
  endtask

  // One clock: check outputs at negedge, drive inputs, advance the model by the coming handshakes.
  task automatic cycle();
    logic [39:0] e;
    logic [16:0] t;
    bit ar_hs, tx_hs, rl_hs;
    @(negedge clk);
    if (done) begin
      chk("done_while_active", inst_active, 1);
      chk("done_ar_left", exp_ar.size(), 0);
      chk("done_txn_left", exp_txn.size(), 0);
      chk("done_outstanding", m_out, 0);
      inst_active = 0;
      n_done++;
    end
    chk("busy", busy, inst_active);
    chk("inst_ready", inst_ready, !inst_active);
    if (!inst_active) begin
      chk("arvalid_idle", arvalid, 0);
      chk("txn_valid_idle", txn_valid, 0);
    end
    if (m_out >= MAXO) chk("arvalid_at_max", arvalid, 0);
    if (p_arv && !p_arr) begin
      chk("ar_hold_valid", arvalid, 1);
      chk("ar_hold_addr", araddr, p_araddr);
      chk("ar_hold_len", arlen, p_arlen);
    end
    if (p_txv && !p_txr) begin
      chk("txn_hold_valid", txn_valid, 1);
      chk("txn_hold_info", txn_info, p_info);
    end

    rst = do_rst;
    inst_valid = want_inst;
    arready = ($urandom_range(99) < ar_pct);
    txn_ready = ($urandom_range(99) < tx_pct);
    rlast = 1'b0;
    if (force_r) begin
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; force_r = 0;
    end else if (r_en && m_out > 0 && $urandom_range(99) < r_pct) begin
      rvalid = 1'b1; rready = 1'($urandom_range(1)); rlast = 1'($urandom_range(1));
    end else begin
      rvalid = 1'($urandom_range(1)); rready = 1'($urandom_range(1));
    end

    if (do_rst) begin
      exp_ar.delete(); exp_txn.delete();
      m_out = 0; inst_active = 0; want_inst = 0;
      p_arv = 0; p_txv = 0;
    end else begin
      ar_hs = arvalid && arready;
      tx_hs = txn_valid && txn_ready;
      rl_hs = rvalid && rready && rlast;
      if (ar_hs) begin
        n_ar++;
        ar_log.push_back({arlen, araddr});
        if (exp_ar.size() == 0) fail("ar_extra");
        else begin
          e = exp_ar.pop_front();
          chk("araddr", araddr, e[31:0]);
          chk("arlen", arlen, e[39:32]);
        end
      end
      if (tx_hs) begin
        n_tx++;
        tx_log.push_back(txn_info);
        if (exp_txn.size() == 0) fail("txn_extra");
        else begin
          t = exp_txn.pop_front();
          chk("txn_info", txn_info, t);
        end
      end
      m_out = m_out + int'(ar_hs) - int'(rl_hs);
      if (m_out < 0) m_out = 0;
      if (inst_valid && inst_ready) begin
        push_model();
        inst_active = 1;
        want_inst = 0;
      end
      p_arv = arvalid; p_arr = arready; p_txv = txn_valid; p_txr = txn_ready;
      p_araddr = araddr; p_arlen = arlen; p_info = txn_info;
    end
  endtask

  task automatic start_inst(input logic [31:0] a, input logic [28:0] s, input int rows, input int cols);
    inst_addr = a;
    inst_stride_ls3 = s;
    inst_num_row_m1 = 8'(rows);
    inst_num_col_m1 = 8'(cols);
    want_inst = 1;
    for (int k = 0; k < 200 && want_inst; k++) cycle();
    if (want_inst) begin
      fail("accept_timeout");
      want_inst = 0;
    end
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = n_done;
    for (int k = 0; k < budget && n_done == d0; k++) cycle();
    chk("done_seen", n_done - d0, 1);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int d_ar, d_tx;
    rst = 1'b1; inst_valid = 1'b0; inst_addr = '0; inst_stride_ls3 = '0;
    inst_num_row_m1 = '0; inst_num_col_m1 = '0;
    arready = 1'b0; txn_ready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    do_rst = 1;
    run_cycles(3);
    @(posedge clk); #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_txn_valid", txn_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_inst_ready", inst_ready, 1);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_txn_info", txn_info, 0);
    do_rst = 0;

    // Three aligned rows, each one beat.
    r_en = 1; r_pct = 100;
    ar_log.delete(); tx_log.delete();
    start_inst(32'h1000, 29'd8, 2, 3);
    wait_done(200);
    chk("t1_ar_count", ar_log.size(), 3);
    chk("t1_ar0", ar_log[0], 40'h00_00001000);
    chk("t1_ar1", ar_log[1], 40'h00_00001040);
    chk("t1_ar2", ar_log[2], 40'h00_00001080);
    chk("t1_first_row0", tx_log[0][15], 1);
    chk("t1_last_row0", tx_log[0][16], 0);
    chk("t1_last_row2", tx_log[2][16], 1);
    d_ar = n_done;
    run_cycles(5);
    chk("t1_single_done", n_done - d_ar, 0);

    // Unaligned single row crossing a beat.
    ar_log.delete(); tx_log.delete();
    start_inst(32'h1004, 29'd0, 0, 3);
    wait_done(200);
    chk("t2_ar", ar_log[0], 40'h01_00001000);
    chk("t2_txn", tx_log[0], 17'h180A0);

    // Outstanding limit with R channel silent, then one rlast releases one more AR.
    r_en = 0;
    d_ar = n_ar;
    start_inst(32'h2000, 29'd2, 5, 3);
    run_cycles(40);
    chk("t3_ar_at_limit", n_ar - d_ar, 4);
    chk("t3_arvalid_low", arvalid, 0);
    force_r = 1;
    run_cycles(10);
    chk("t3_ar_after_rlast", n_ar - d_ar, 5);
    r_en = 1;
    wait_done(400);

    // AR backpressure while txn completes independently.
    ar_pct = 0;
    d_ar = n_ar; d_tx = n_tx;
    start_inst(32'h3008, 29'd4, 1, 7);
    run_cycles(6);
    chk("t4_txn_once", n_tx - d_tx, 1);
    chk("t4_no_ar", n_ar - d_ar, 0);
    chk("t4_arvalid_held", arvalid, 1);
    ar_pct = 100;
    wait_done(200);
    chk("t4_ar_total", n_ar - d_ar, 2);
    chk("t4_txn_total", n_tx - d_tx, 2);

    // Address wrap; rlast returns overlap the next AR handshake.
    ar_log.delete();
    start_inst(32'hFFFFFFC0, 29'd8, 1, 3);
    wait_done(200);
    chk("t5_ar0", ar_log[0][31:0], 32'hFFFFFFC0);
    chk("t5_ar1_wrap", ar_log[1][31:0], 32'h0);

    // Reset mid-instruction with bursts outstanding, then a stray rlast.
    r_en = 0;
    d_ar = n_ar;
    start_inst(32'h4000, 29'd16, 5, 3);
    for (int k = 0; k < 50 && (n_ar - d_ar) < 2; k++) cycle();
    chk("t6_two_out", n_ar - d_ar, 2);
    do_rst = 1;
    cycle();
    do_rst = 0;
    @(posedge clk); #1;
    chk("t6_arvalid", arvalid, 0);
    chk("t6_txn_valid", txn_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_inst_ready", inst_ready, 1);
    force_r = 1;
    cycle();
    r_en = 1;
    start_inst(32'h5000, 29'd8, 4, 3);
    wait_done(300);

    // Randomized instructions and channel timing.
    for (int t = 0; t < 30; t++) begin
      ar_pct = $urandom_range(30, 100);
      tx_pct = $urandom_range(30, 100);
      r_pct  = $urandom_range(20, 100);
      start_inst($urandom(),
                 ($urandom_range(3) == 0) ? 29'($urandom()) : 29'($urandom_range(0, 40)),
                 $urandom_range(0, 4), $urandom_range(0, 40));
      wait_done(600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
